// File: rtl/schedule1_pkg.sv
// schedule1 shared types: lane field widths, opcode constants and the NOP lane.
// Optional build switch used by schedule1: SCHEDULE1_PERF_CNT_EN.
package schedule1_pkg;

  localparam int PC_W  = 32;
  localparam int OP_W  = 17;
  localparam int REG_W = 5;
  localparam int CSR_W = 12;
  localparam int IMM_W = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // addi x0,x0,0 in {opcode,funct3,funct7} layout
  localparam logic [OP_W-1:0] NOP_OPCODE = {OPC_OP_IMM, 10'b0};

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [CSR_W-1:0] csr;
    logic [IMM_W-1:0] imm;
  } lane_t;

  localparam lane_t NOP_LANE = '{
    pc:     '0,
    opcode: NOP_OPCODE,
    rd:     '0,
    rs1:    '0,
    rs2:    '0,
    csr:    '0,
    imm:    '0
  };

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return op[OP_W-1 -: 7] == OPC_LOAD;
  endfunction

endpackage

// File: rtl/schedule1_if.sv
// schedule1 lane bundle: per-lane decoded fields in, one issued instruction out.
// Master is the upstream/check side, slave is the scheduler.
interface schedule1_if #(
  parameter int PNUMS = 2,
  parameter int PID_W = 4
);
  import schedule1_pkg::*;

  logic [PNUMS-1:0]       CHECK_ACCEPT;
  logic [PC_W*PNUMS-1:0]  CHECK_PC;
  logic [OP_W*PNUMS-1:0]  CHECK_OPCODE;
  logic [REG_W*PNUMS-1:0] CHECK_RD;
  logic [REG_W*PNUMS-1:0] CHECK_RS1;
  logic [REG_W*PNUMS-1:0] CHECK_RS2;
  logic [CSR_W*PNUMS-1:0] CHECK_CSR;
  logic [IMM_W*PNUMS-1:0] CHECK_IMM;

  logic                   SCHEDULE1_HAZARD;
  logic [PID_W-1:0]       SCHEDULE1_PID;
  logic [PC_W-1:0]        SCHEDULE1_PC;
  logic [OP_W-1:0]        SCHEDULE1_OPCODE;
  logic [REG_W-1:0]       SCHEDULE1_RD;
  logic [REG_W-1:0]       SCHEDULE1_RS1;
  logic [REG_W-1:0]       SCHEDULE1_RS2;
  logic [CSR_W-1:0]       SCHEDULE1_CSR;
  logic [IMM_W-1:0]       SCHEDULE1_IMM;
  logic                   SCHEDULE1_ILLEGAL;

  modport master (
    output CHECK_ACCEPT, CHECK_PC, CHECK_OPCODE,
    output CHECK_RD, CHECK_RS1, CHECK_RS2,
    output CHECK_CSR, CHECK_IMM,
    input  SCHEDULE1_HAZARD, SCHEDULE1_PID,
    input  SCHEDULE1_PC, SCHEDULE1_OPCODE,
    input  SCHEDULE1_RD, SCHEDULE1_RS1, SCHEDULE1_RS2,
    input  SCHEDULE1_CSR, SCHEDULE1_IMM,
    input  SCHEDULE1_ILLEGAL
  );

  modport slave (
    input  CHECK_ACCEPT, CHECK_PC, CHECK_OPCODE,
    input  CHECK_RD, CHECK_RS1, CHECK_RS2,
    input  CHECK_CSR, CHECK_IMM,
    output SCHEDULE1_HAZARD, SCHEDULE1_PID,
    output SCHEDULE1_PC, SCHEDULE1_OPCODE,
    output SCHEDULE1_RD, SCHEDULE1_RS1, SCHEDULE1_RS2,
    output SCHEDULE1_CSR, SCHEDULE1_IMM,
    output SCHEDULE1_ILLEGAL
  );

endinterface

// File: rtl/schedule1_load_tracker.sv
// schedule1 pending-load shift register (entry 0 newest) and load-use compare.
// Hazard is forced low during flush since the flush clears all entries.
module schedule1_load_tracker
  import schedule1_pkg::*;
#(
  parameter int LOAD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             advance,
  input  logic             push_vld,
  input  logic [REG_W-1:0] push_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             hazard
);

  logic [LOAD_LAT-1:0] vld;
  logic [REG_W-1:0]    rd [LOAD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < LOAD_LAT; i++)
        rd[i] <= '0;
    end else if (flush) begin
      vld <= '0;
      for (int i = 0; i < LOAD_LAT; i++)
        rd[i] <= '0;
    end else if (advance) begin
      for (int i = LOAD_LAT - 1; i >= 1; i--) begin
        vld[i] <= vld[i-1];
        rd[i]  <= rd[i-1];
      end
      vld[0] <= push_vld;
      rd[0]  <= push_vld ? push_rd : '0;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (vld[i] &&
          ((rs1 != '0 && rd[i] == rs1) ||
           (rs2 != '0 && rd[i] == rs2)))
        hazard = 1'b1;
    end
    if (flush)
      hazard = 1'b0;
  end

endmodule

// File: rtl/schedule1.sv
// schedule1: picks one of PNUMS decoded lanes, bubbles on load-use hazards.
// Build switch SCHEDULE1_PERF_CNT_EN adds issue/bubble counters.
module schedule1
  import schedule1_pkg::*;
#(
  parameter int unsigned COP_NUMS = 32'd1,
  parameter int          PNUMS    = int'(COP_NUMS) + 1,
  parameter int          LOAD_LAT = 2,
  parameter int          PID_W    = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FLUSH,
  input  logic        STALL,
  input  logic        MMU_WAIT,
`ifdef SCHEDULE1_PERF_CNT_EN
  output logic [31:0] PERF_ISSUE,
  output logic [31:0] PERF_BUBBLE,
`endif
  schedule1_if.slave  bus
);

  lane_t            lanes [PNUMS];
  lane_t            sel_lane;
  logic [PID_W-1:0] sel_pid;
  logic             sel_ill;
  logic             hazard;
  logic             advance;
  logic             push_vld;

  lane_t            out_lane;
  logic [PID_W-1:0] out_pid;
  logic             out_ill;

  for (genvar g = 0; g < PNUMS; g++) begin : g_lane
    assign lanes[g] = '{
      pc:     bus.CHECK_PC[PC_W*g +: PC_W],
      opcode: bus.CHECK_OPCODE[OP_W*g +: OP_W],
      rd:     bus.CHECK_RD[REG_W*g +: REG_W],
      rs1:    bus.CHECK_RS1[REG_W*g +: REG_W],
      rs2:    bus.CHECK_RS2[REG_W*g +: REG_W],
      csr:    bus.CHECK_CSR[CSR_W*g +: CSR_W],
      imm:    bus.CHECK_IMM[IMM_W*g +: IMM_W]
    };
  end

  // Coprocessors outrank the main core; lowest coprocessor index wins.
  always_comb begin
    logic found;
    found    = 1'b0;
    sel_lane = lanes[0];
    sel_pid  = '0;
    sel_ill  = 1'b0;
    for (int i = PNUMS - 1; i >= 1; i--) begin
      if (bus.CHECK_ACCEPT[i]) begin
        found    = 1'b1;
        sel_lane = lanes[i];
        sel_pid  = PID_W'(i);
      end
    end
    if (!found && !bus.CHECK_ACCEPT[0]) begin
      sel_ill     = 1'b1;
      sel_lane.rd = '0;
    end
  end

  assign advance  = !STALL && !MMU_WAIT;
  assign push_vld = !hazard && !sel_ill &&
                    is_load(sel_lane.opcode) &&
                    sel_lane.rd != '0;

  schedule1_load_tracker #(
    .LOAD_LAT (LOAD_LAT)
  ) u_tracker (
    .clk      (CLK),
    .rst_n    (RST_N),
    .flush    (FLUSH),
    .advance  (advance),
    .push_vld (push_vld),
    .push_rd  (sel_lane.rd),
    .rs1      (sel_lane.rs1),
    .rs2      (sel_lane.rs2),
    .hazard   (hazard)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_lane <= NOP_LANE;
      out_pid  <= '0;
      out_ill  <= 1'b0;
    end else if (FLUSH) begin
      out_lane <= NOP_LANE;
      out_pid  <= '0;
      out_ill  <= 1'b0;
    end else if (advance) begin
      if (hazard) begin
        out_lane <= NOP_LANE;
        out_pid  <= '0;
        out_ill  <= 1'b0;
      end else begin
        out_lane <= sel_lane;
        out_pid  <= sel_pid;
        out_ill  <= sel_ill;
      end
    end
  end

  assign bus.SCHEDULE1_HAZARD  = hazard;
  assign bus.SCHEDULE1_PID     = out_pid;
  assign bus.SCHEDULE1_PC      = out_lane.pc;
  assign bus.SCHEDULE1_OPCODE  = out_lane.opcode;
  assign bus.SCHEDULE1_RD      = out_lane.rd;
  assign bus.SCHEDULE1_RS1     = out_lane.rs1;
  assign bus.SCHEDULE1_RS2     = out_lane.rs2;
  assign bus.SCHEDULE1_CSR     = out_lane.csr;
  assign bus.SCHEDULE1_IMM     = out_lane.imm;
  assign bus.SCHEDULE1_ILLEGAL = out_ill;

`ifdef SCHEDULE1_PERF_CNT_EN
  // Counters survive FLUSH; only reset clears them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PERF_ISSUE  <= '0;
      PERF_BUBBLE <= '0;
    end else if (advance && !FLUSH) begin
      if (hazard)
        PERF_BUBBLE <= PERF_BUBBLE + 32'd1;
      else
        PERF_ISSUE  <= PERF_ISSUE + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_schedule1.sv
// schedule1 bench: vector table for lane select/illegal/hazard,
// plus directed load-use, stall/flush and async reset sequences.
module tb_schedule1;
  import schedule1_pkg::*;

  localparam logic [16:0] NOP = {7'b0010011, 10'b0};
  localparam logic [16:0] ADD = {7'b0110011, 10'b0};
  localparam logic [16:0] LW  = {7'b0000011, 3'b010, 7'b0};

  logic CLK = 1'b0;
  logic RST_N;
  logic FLUSH;
  logic STALL;
  logic MMU_WAIT;
`ifdef SCHEDULE1_PERF_CNT_EN
  logic [31:0] PERF_ISSUE;
  logic [31:0] PERF_BUBBLE;
`endif

  schedule1_if #(.PNUMS(2), .PID_W(4)) bus ();

  schedule1 #(
    .COP_NUMS (32'd1),
    .LOAD_LAT (2),
    .PID_W    (4)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .FLUSH    (FLUSH),
    .STALL    (STALL),
    .MMU_WAIT (MMU_WAIT),
`ifdef SCHEDULE1_PERF_CNT_EN
    .PERF_ISSUE  (PERF_ISSUE),
    .PERF_BUBBLE (PERF_BUBBLE),
`endif
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_lanes(input logic [1:0] acc,
                           input logic [31:0] pc0, pc1,
                           input logic [16:0] op0, op1,
                           input logic [4:0] rd0, rd1,
                           input logic [4:0] rs1_0, rs2_1);
    bus.CHECK_ACCEPT = acc;
    bus.CHECK_PC     = {pc1, pc0};
    bus.CHECK_OPCODE = {op1, op0};
    bus.CHECK_RD     = {rd1, rd0};
    bus.CHECK_RS1    = {5'd0, rs1_0};
    bus.CHECK_RS2    = {rs2_1, 5'd0};
    bus.CHECK_CSR    = {12'h7c1, 12'h300};
    bus.CHECK_IMM    = {pc1 + 32'd1, pc0 + 32'd1};
  endtask

  typedef struct {
    logic [1:0]  acc;
    logic [31:0] pc0, pc1;
    logic [16:0] op0, op1;
    logic [4:0]  rd0, rd1, rs1_0, rs2_1;
    logic        exp_hz;
    logic [3:0]  exp_pid;
    logic [31:0] exp_pc;
    logic [16:0] exp_op;
    logic [4:0]  exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{2'b11, 32'h200, 32'h100, ADD, ADD, 5'd9, 5'd7, 5'd0, 5'd0,
                 1'b0, 4'd1, 32'h100, ADD, 5'd7, 1'b0};
    vecs[1]  = '{2'b01, 32'h200, 32'h100, ADD, ADD, 5'd9, 5'd7, 5'd0, 5'd0,
                 1'b0, 4'd0, 32'h200, ADD, 5'd9, 1'b0};
    vecs[2]  = '{2'b10, 32'h200, 32'h100, ADD, ADD, 5'd9, 5'd7, 5'd0, 5'd0,
                 1'b0, 4'd1, 32'h100, ADD, 5'd7, 1'b0};
    vecs[3]  = '{2'b00, 32'h40, 32'h100, ADD, ADD, 5'd5, 5'd7, 5'd0, 5'd0,
                 1'b0, 4'd0, 32'h40, ADD, 5'd0, 1'b1};
    vecs[4]  = '{2'b00, 32'h44, 32'h100, LW, ADD, 5'd5, 5'd7, 5'd0, 5'd0,
                 1'b0, 4'd0, 32'h44, LW, 5'd0, 1'b1};
    vecs[5]  = '{2'b10, 32'h200, 32'h104, ADD, ADD, 5'd9, 5'd7, 5'd0, 5'd5,
                 1'b0, 4'd1, 32'h104, ADD, 5'd7, 1'b0};
    vecs[6]  = '{2'b01, 32'h208, 32'h104, LW, ADD, 5'd4, 5'd7, 5'd0, 5'd0,
                 1'b0, 4'd0, 32'h208, LW, 5'd4, 1'b0};
    vecs[7]  = '{2'b10, 32'h208, 32'h108, ADD, ADD, 5'd9, 5'd7, 5'd0, 5'd4,
                 1'b1, 4'd0, 32'h0, NOP, 5'd0, 1'b0};
    vecs[8]  = '{2'b10, 32'h208, 32'h108, ADD, ADD, 5'd9, 5'd7, 5'd0, 5'd4,
                 1'b1, 4'd0, 32'h0, NOP, 5'd0, 1'b0};
    vecs[9]  = '{2'b10, 32'h208, 32'h108, ADD, ADD, 5'd9, 5'd7, 5'd0, 5'd4,
                 1'b0, 4'd1, 32'h108, ADD, 5'd7, 1'b0};
    vecs[10] = '{2'b11, 32'h20c, 32'h10c, ADD, LW, 5'd9, 5'd0, 5'd0, 5'd0,
                 1'b0, 4'd1, 32'h10c, LW, 5'd0, 1'b0};
    vecs[11] = '{2'b01, 32'h20c, 32'h110, ADD, ADD, 5'd9, 5'd7, 5'd9, 5'd0,
                 1'b0, 4'd0, 32'h20c, ADD, 5'd9, 1'b0};

    RST_N = 1'b0;
    FLUSH = 1'b0;
    STALL = 1'b0;
    MMU_WAIT = 1'b0;
    set_lanes(2'b11, 32'h200, 32'h100, ADD, ADD, 5'd9, 5'd7, 5'd0, 5'd0);
    step();
    step();
    chk("rst_pid", 64'(bus.SCHEDULE1_PID), 64'd0);
    chk("rst_pc", 64'(bus.SCHEDULE1_PC), 64'd0);
    chk("rst_op", 64'(bus.SCHEDULE1_OPCODE), 64'(NOP));
    chk("rst_rd", 64'(bus.SCHEDULE1_RD), 64'd0);
    chk("rst_ill", 64'(bus.SCHEDULE1_ILLEGAL), 64'd0);
    chk("rst_hz", 64'(bus.SCHEDULE1_HAZARD), 64'd0);
    RST_N = 1'b1;

    for (int i = 0; i < 12; i++) begin
      set_lanes(vecs[i].acc, vecs[i].pc0, vecs[i].pc1,
                vecs[i].op0, vecs[i].op1, vecs[i].rd0,
                vecs[i].rd1, vecs[i].rs1_0, vecs[i].rs2_1);
      #1;
      chk($sformatf("v%0d_hz", i), 64'(bus.SCHEDULE1_HAZARD),
          64'(vecs[i].exp_hz));
      step();
      chk($sformatf("v%0d_pid", i), 64'(bus.SCHEDULE1_PID),
          64'(vecs[i].exp_pid));
      chk($sformatf("v%0d_pc", i), 64'(bus.SCHEDULE1_PC),
          64'(vecs[i].exp_pc));
      chk($sformatf("v%0d_op", i), 64'(bus.SCHEDULE1_OPCODE),
          64'(vecs[i].exp_op));
      chk($sformatf("v%0d_rd", i), 64'(bus.SCHEDULE1_RD),
          64'(vecs[i].exp_rd));
      chk($sformatf("v%0d_ill", i), 64'(bus.SCHEDULE1_ILLEGAL),
          64'(vecs[i].exp_ill));
    end

    // lane 0 load then dependent add held: two bubbles
    set_lanes(2'b01, 32'h300, 32'h0, LW, ADD, 5'd3, 5'd0, 5'd0, 5'd0);
    step();
    chk("lu_lw_pc", 64'(bus.SCHEDULE1_PC), 64'h300);
    set_lanes(2'b01, 32'h304, 32'h0, ADD, ADD, 5'd6, 5'd0, 5'd3, 5'd0);
    #1;
    chk("lu_hz0", 64'(bus.SCHEDULE1_HAZARD), 64'd1);
    step();
    chk("lu_b0_op", 64'(bus.SCHEDULE1_OPCODE), 64'(NOP));
    chk("lu_hz1", 64'(bus.SCHEDULE1_HAZARD), 64'd1);
    step();
    chk("lu_b1_pc", 64'(bus.SCHEDULE1_PC), 64'h0);
    chk("lu_hz2", 64'(bus.SCHEDULE1_HAZARD), 64'd0);
    step();
    chk("lu_add_pc", 64'(bus.SCHEDULE1_PC), 64'h304);
    chk("lu_add_rd", 64'(bus.SCHEDULE1_RD), 64'd6);

    // rs1 = x0 never depends on a load
    set_lanes(2'b01, 32'h310, 32'h0, LW, ADD, 5'd3, 5'd0, 5'd0, 5'd0);
    step();
    set_lanes(2'b01, 32'h314, 32'h0, ADD, ADD, 5'd6, 5'd0, 5'd0, 5'd0);
    #1;
    chk("x0_hz", 64'(bus.SCHEDULE1_HAZARD), 64'd0);
    step();
    chk("x0_pc", 64'(bus.SCHEDULE1_PC), 64'h314);

    // stall during hazard freezes, then flush under stall
    set_lanes(2'b01, 32'h320, 32'h0, LW, ADD, 5'd3, 5'd0, 5'd0, 5'd0);
    step();
    set_lanes(2'b01, 32'h324, 32'h0, ADD, ADD, 5'd6, 5'd0, 5'd3, 5'd0);
    STALL = 1'b1;
    step();
    step();
    step();
    chk("st_pc", 64'(bus.SCHEDULE1_PC), 64'h320);
    chk("st_hz", 64'(bus.SCHEDULE1_HAZARD), 64'd1);
    STALL = 1'b0;
    MMU_WAIT = 1'b1;
    step();
    step();
    chk("mw_pc", 64'(bus.SCHEDULE1_PC), 64'h320);
    chk("mw_hz", 64'(bus.SCHEDULE1_HAZARD), 64'd1);
    MMU_WAIT = 1'b0;
    STALL = 1'b1;
    FLUSH = 1'b1;
    #1;
    chk("fl_hz_gate", 64'(bus.SCHEDULE1_HAZARD), 64'd0);
    step();
    FLUSH = 1'b0;
    #1;
    chk("fl_pc", 64'(bus.SCHEDULE1_PC), 64'h0);
    chk("fl_op", 64'(bus.SCHEDULE1_OPCODE), 64'(NOP));
    chk("fl_hz", 64'(bus.SCHEDULE1_HAZARD), 64'd0);
    STALL = 1'b0;
    step();
    chk("fl_add_pc", 64'(bus.SCHEDULE1_PC), 64'h324);

    // async reset between clock edges
    set_lanes(2'b10, 32'h200, 32'h180, ADD, ADD, 5'd9, 5'd7, 5'd0, 5'd0);
    step();
    chk("ar_pre_pc", 64'(bus.SCHEDULE1_PC), 64'h180);
    #2;
    RST_N = 1'b0;
    #1;
    chk("ar_pc", 64'(bus.SCHEDULE1_PC), 64'h0);
    chk("ar_pid", 64'(bus.SCHEDULE1_PID), 64'd0);
    chk("ar_op", 64'(bus.SCHEDULE1_OPCODE), 64'(NOP));
    chk("ar_ill", 64'(bus.SCHEDULE1_ILLEGAL), 64'd0);
    step();
    RST_N = 1'b1;

`ifdef SCHEDULE1_PERF_CNT_EN
    set_lanes(2'b01, 32'h400, 32'h0, LW, ADD, 5'd3, 5'd0, 5'd0, 5'd0);
    step();
    set_lanes(2'b01, 32'h404, 32'h0, ADD, ADD, 5'd6, 5'd0, 5'd3, 5'd0);
    step();
    step();
    step();
    STALL = 1'b1;
    chk("pf_add_pc", 64'(bus.SCHEDULE1_PC), 64'h404);
    step();
    chk("pf_issue", 64'(PERF_ISSUE), 64'd2);
    chk("pf_bubble", 64'(PERF_BUBBLE), 64'd2);
    STALL = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
